// File: rtl/wb_axi_bridge.sv
// wb_axi_bridge: Wishbone slave in front of one accelerator. Low half of the
// 256-byte page is an AXI4-Lite master window; 0x80/0x84 reach a pair of
// AXI4-Stream FIFOs; 0x88 is a status word with sticky timeout flags and the
// two FIFO levels. Every wait is bounded by TIMEOUT cycles.
module wb_axi_bridge #(
  parameter logic [7:0] BASE_HI    = 8'h30,
  parameter int         AXIL_AW    = 12,
  parameter int         FIFO_DEPTH = 8,
  parameter int         TIMEOUT    = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               awvalid,
  input  logic               awready,
  output logic [AXIL_AW-1:0] awaddr,
  output logic               wvalid,
  input  logic               wready,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               arvalid,
  input  logic               arready,
  output logic [AXIL_AW-1:0] araddr,
  input  logic               rvalid,
  output logic               rready,
  input  logic [31:0]        rdata,
  output logic               ss_tvalid,
  input  logic               ss_tready,
  output logic [31:0]        ss_tdata,
  output logic               ss_tlast,
  input  logic               sm_tvalid,
  output logic               sm_tready,
  input  logic [31:0]        sm_tdata,
  input  logic               sm_tlast
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_AR, S_R, S_SS, S_SM, S_ACK} state_t;
  state_t state, state_nxt;

  // FIFO 0 carries the ss stream (to the core), FIFO 1 the sm stream; each
  // entry is {tlast, data}.
  logic [32:0]      fifo_mem [2][FIFO_DEPTH];
  logic [AW:0]      wr_ptr [2];
  logic [AW:0]      rd_ptr [2];
  logic [LVL_W-1:0] level [2];
  logic [32:0]      head [2];
  logic [32:0]      push_data [2];
  logic [1:0]       push, pop, full, empty;

  logic             ss_push, sm_pop, ss_pop, sm_push, ss_space;
  logic             req, is_axi, is_strm, is_stat, in_wait, expired;
  logic             aw_done, w_done, aw_ok, w_ok, run_q;
  logic             axi_err, strm_err, axi_abort, strm_abort, rd_abort;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      status;
  logic             unused_ok;

  assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == BASE_HI) & !wbs_ack_o;
  assign is_axi  = !wbs_adr_i[7];
  assign is_strm = (wbs_adr_i[7:0] == 8'h80) || (wbs_adr_i[7:0] == 8'h84);
  assign is_stat = (wbs_adr_i[7:0] == 8'h88);
  assign in_wait = (state != S_IDLE) && (state != S_ACK);
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
  assign aw_ok   = aw_done | awready;
  assign w_ok    = w_done | wready;

  assign ss_tvalid = !empty[0];
  assign ss_pop    = ss_tvalid & ss_tready;
  // A pop in the same cycle frees the slot, so a full ss FIFO can still take a word.
  assign ss_space  = !full[0] | ss_pop;
  assign ss_tdata  = ss_tvalid ? head[0][31:0] : '0;
  assign ss_tlast  = ss_tvalid ? head[0][32] : 1'b0;
  assign sm_tready = run_q & !full[1];
  assign sm_push   = sm_tvalid & sm_tready;

  assign push         = {sm_push, ss_push};
  assign pop          = {sm_pop, ss_pop};
  assign push_data[0] = {wbs_adr_i[2], wbs_dat_i};
  assign push_data[1] = {sm_tlast, sm_tdata};

  assign status    = {axi_err, strm_err, 14'd0, 8'(level[1]), 8'(level[0])};
  // sm_tlast is stored but never consumed; upper address bits are don't-care.
  assign unused_ok = ^{head[1][32], wbs_adr_i};

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode: dispatch on address, then wait for handshake or timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (req) begin
        if (is_axi)                    state_nxt = wbs_we_i ? S_WR : S_AR;
        else if (is_strm && wbs_we_i)  state_nxt = ss_space ? S_ACK : S_SS;
        else if (is_strm)              state_nxt = empty[1] ? S_SM : S_ACK;
        else                           state_nxt = S_ACK;
      end
      S_WR:    if ((aw_ok && w_ok) || expired) state_nxt = S_ACK;
      S_AR:    if (arready) state_nxt = S_R; else if (expired) state_nxt = S_ACK;
      S_R:     if (rvalid || expired) state_nxt = S_ACK;
      S_SS:    if (ss_space || expired) state_nxt = S_ACK;
      S_SM:    if (!empty[1] || expired) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs per state: AXI valids/readies, FIFO strobes and abort flags.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    ss_push    = 1'b0;
    sm_pop     = 1'b0;
    axi_abort  = 1'b0;
    strm_abort = 1'b0;
    wbs_ack_o  = (state == S_ACK);
    unique case (state)
      S_IDLE: if (req && is_strm) begin
        if (wbs_we_i) ss_push = ss_space;
        else          sm_pop  = !empty[1];
      end
      S_WR: begin
        awvalid   = !aw_done;
        wvalid    = !w_done;
        axi_abort = expired && !(aw_ok && w_ok);
      end
      S_AR: begin
        arvalid   = 1'b1;
        axi_abort = expired && !arready;
      end
      S_R: begin
        rready    = 1'b1;
        axi_abort = expired && !rvalid;
      end
      S_SS: begin
        ss_push    = ss_space;
        strm_abort = expired && !ss_space;
      end
      S_SM: begin
        sm_pop     = !empty[1];
        strm_abort = expired && empty[1];
      end
      default: ;
    endcase
    rd_abort = (axi_abort && state != S_WR) || (strm_abort && state == S_SM);
  end

  // Request capture, AW/W tracking, timeout counter, read data and sticky flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_dat_o <= '0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cnt       <= '0;
      axi_err   <= 1'b0;
      strm_err  <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
      run_q <= 1'b1;
      if (state != state_nxt) cnt <= '0;
      else if (in_wait)       cnt <= cnt + CNT_W'(1);
      if (state == S_IDLE && req) begin
        if (is_axi && wbs_we_i) begin
          awaddr  <= wbs_adr_i[AXIL_AW-1:0];
          wdata   <= wbs_dat_i;
          wstrb   <= wbs_sel_i;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else if (is_axi) begin
          araddr <= wbs_adr_i[AXIL_AW-1:0];
        end else if (is_stat && wbs_we_i) begin
          if (wbs_dat_i[31]) axi_err  <= 1'b0;
          if (wbs_dat_i[30]) strm_err <= 1'b0;
        end else if (is_stat) begin
          wbs_dat_o <= status;
        end else if (!is_strm && !wbs_we_i) begin
          wbs_dat_o <= '0;
        end
      end
      if (state == S_WR) begin
        if (awready) aw_done <= 1'b1;
        if (wready)  w_done  <= 1'b1;
      end
      if (state == S_R && rvalid) wbs_dat_o <= rdata;
      if (sm_pop)                 wbs_dat_o <= head[1][31:0];
      if (axi_abort)              axi_err   <= 1'b1;
      if (strm_abort)             strm_err  <= 1'b1;
      if (rd_abort)               wbs_dat_o <= '1;
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge wb_clk_i) begin
    for (int f = 0; f < 2; f++) begin
      if (wb_rst_i) begin
        wr_ptr[f] <= '0;
        rd_ptr[f] <= '0;
      end else begin
        if (push[f]) wr_ptr[f] <= wr_ptr[f] + LVL_W'(1);
        if (pop[f])  rd_ptr[f] <= rd_ptr[f] + LVL_W'(1);
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: storage is not reset; pointers define validity and ss outputs are masked while empty.
    for (int f = 0; f < 2; f++)
      if (push[f]) fifo_mem[f][wr_ptr[f][AW-1:0]] <= push_data[f];
  end

  // FIFO flags, level and head-of-queue.
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      level[f] = wr_ptr[f] - rd_ptr[f];
      full[f]  = (level[f] == LVL_W'(FIFO_DEPTH));
      empty[f] = (wr_ptr[f] == rd_ptr[f]);
      head[f]  = fifo_mem[f][rd_ptr[f][AW-1:0]];
    end
  end

endmodule

// File: tb/tb_wb_axi_bridge.sv
// Directed bench for wb_axi_bridge: AXI-Lite write/read handshakes, stream
// FIFO fill/stall/drain, tlast, timeouts with sticky status, full-FIFO
// push/pop overlap and mid-transaction reset.
module tb_wb_axi_bridge;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        awvalid, wvalid, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic        ss_tvalid, ss_tlast, sm_tready;
  logic        ss_tready = 1'b0, sm_tvalid = 1'b0, sm_tlast = 1'b0;
  logic [31:0] ss_tdata, sm_tdata = '0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;
  int          lat;
  int          k;
  logic [32:0] ss_q[$];

  wb_axi_bridge #(.BASE_HI(8'h30), .AXIL_AW(12), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Record every accepted ss beat mid-cycle, when handshake signals are stable.
  always @(negedge wb_clk_i)
    if (!wb_rst_i && ss_tvalid && ss_tready) ss_q.push_back({ss_tlast, ss_tdata});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One Wishbone cycle; lat = cycles from the sampling edge to ack (1 = next cycle), 0 = no ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdat, output int latency);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = 4'hF;
    latency = 0;
    rdat    = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        latency = c;
        rdat    = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", wbs_ack_o, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_valids", {awvalid, wvalid, arvalid, rready, ss_tvalid}, 0);
    check("rst_sm_tready", sm_tready, 0);
    check("rst_ss_out", {ss_tlast, ss_tdata}, 0);
    check("rst_axi_out", {awaddr, araddr, wdata, wstrb}, 0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("sm_tready_after_rst", sm_tready, 1);

    // AXI-Lite write: awready two cycles before wready
    fork
      wb_xfer(1'b1, 32'h3000_0010, 32'h5, rd, lat);
      begin
        k = 0;
        while (!awvalid && k < 20) begin @(posedge wb_clk_i); #1; k++; end
        check("aw_seen", awvalid, 1);
        check("w_seen", wvalid, 1);
        awready = 1'b1;
        @(posedge wb_clk_i); #1;
        awready = 1'b0;
        check("aw_drop", awvalid, 0);
        check("w_hold", wvalid, 1);
        check("awaddr", awaddr, 32'h010);
        check("wdata", wdata, 32'h5);
        check("wstrb", wstrb, 4'hF);
        @(posedge wb_clk_i); #1;
        check("no_early_ack", wbs_ack_o, 0);
        wready = 1'b1;
        @(posedge wb_clk_i); #1;
        wready = 1'b0;
        check("w_drop", wvalid, 0);
      end
    join
    check("axw_lat", lat, 4);
    check("axw_ack_width", wbs_ack_o, 0);

    // AXI-Lite read: arready after 3 cycles, rdata = 4
    fork
      wb_xfer(1'b0, 32'h3000_0000, 32'h0, rd, lat);
      begin
        k = 0;
        while (!arvalid && k < 20) begin @(posedge wb_clk_i); #1; k++; end
        check("ar_seen", arvalid, 1);
        repeat (3) begin @(posedge wb_clk_i); #1; end
        check("ar_hold", arvalid, 1);
        check("rready_low", rready, 0);
        arready = 1'b1;
        @(posedge wb_clk_i); #1;
        arready = 1'b0;
        check("ar_drop", arvalid, 0);
        check("rready_on", rready, 1);
        rvalid = 1'b1; rdata = 32'h4;
        @(posedge wb_clk_i); #1;
        rvalid = 1'b0; rdata = 32'h0;
      end
    join
    check("axr_lat", lat, 6);
    check("axr_data", rd, 32'h4);
    check("axr_ack_width", wbs_ack_o, 0);

    // Unmapped page offsets and a foreign base address
    wb_xfer(1'b1, 32'h3000_0090, 32'h1234, rd, lat);
    check("unmap_wr_lat", lat, 1);
    wb_xfer(1'b0, 32'h3000_00F0, 32'h0, rd, lat);
    check("unmap_rd_lat", lat, 1);
    check("unmap_rd_data", rd, 32'h0);
    wb_xfer(1'b0, 32'h2000_0088, 32'h0, rd, lat);
    check("foreign_no_ack", lat, 0);

    // ss FIFO: 8 writes fill it, 9th stalls until ss_tready
    for (int i = 0; i < DEPTH; i++) begin
      wb_xfer(1'b1, 32'h3000_0080, 32'h100 + i, rd, lat);
      check($sformatf("ss_push%0d_lat", i), lat, 1);
    end
    wb_xfer(1'b0, 32'h3000_0088, 32'h0, rd, lat);
    check("status_ss_full", rd, 32'h0000_0008);
    check("ss_head", {ss_tvalid, ss_tdata}, {1'b1, 32'h100});
    fork
      wb_xfer(1'b1, 32'h3000_0080, 32'h108, rd, lat);
      begin
        repeat (3) @(posedge wb_clk_i);
        #1;
        ss_tready = 1'b1;
      end
    join
    check("ss_stall_lat", lat, 4);
    repeat (12) @(posedge wb_clk_i);
    #1;
    check("ss_beats", ss_q.size(), 9);
    for (int i = 0; i < 9 && i < ss_q.size(); i++)
      check($sformatf("ss_beat%0d", i), ss_q[i][31:0], 32'h100 + i);
    if (ss_q.size() >= 9) check("ss_beat8_tlast", ss_q[8][32], 0);

    // tlast via 0x84, then empty sm read times out
    wb_xfer(1'b1, 32'h3000_0084, 32'hABCD, rd, lat);
    check("tlast_wr_lat", lat, 1);
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("tlast_beats", ss_q.size(), 10);
    if (ss_q.size() >= 10) check("tlast_beat", ss_q[9], {1'b1, 32'hABCD});
    wb_xfer(1'b0, 32'h3000_0080, 32'h0, rd, lat);
    check("sm_tmo_lat", lat, TMO + 1);
    check("sm_tmo_data", rd, 32'hFFFF_FFFF);
    wb_xfer(1'b0, 32'h3000_0088, 32'h0, rd, lat);
    check("status_strm_err", rd, 32'h4000_0000);
    wb_xfer(1'b1, 32'h3000_0088, 32'h4000_0000, rd, lat);
    wb_xfer(1'b0, 32'h3000_0088, 32'h0, rd, lat);
    check("status_cleared", rd, 32'h0);

    // sm FIFO: fill, then pop while sm_tvalid is held with FIFO full
    for (int i = 0; i < DEPTH; i++) begin
      sm_tvalid = 1'b1; sm_tdata = 32'h200 + i;
      @(posedge wb_clk_i); #1;
    end
    sm_tdata = 32'h208;
    check("sm_full_tready", sm_tready, 0);
    wb_xfer(1'b0, 32'h3000_0088, 32'h0, rd, lat);
    check("status_sm_full", rd, 32'h0000_0800);
    check("sm_tready_pop_cycle", sm_tready, 0);
    wb_xfer(1'b0, 32'h3000_0080, 32'h0, rd, lat);
    sm_tvalid = 1'b0;
    check("sm_pop_lat", lat, 1);
    check("sm_pop0", rd, 32'h200);
    wb_xfer(1'b0, 32'h3000_0088, 32'h0, rd, lat);
    check("status_sm_refill", rd, 32'h0000_0800);
    for (int i = 1; i <= DEPTH; i++) begin
      wb_xfer(1'b0, 32'h3000_0080, 32'h0, rd, lat);
      check($sformatf("sm_pop%0d", i), rd, 32'h200 + i);
    end

    // AXI-Lite write timeout and a parked ss word
    ss_tready = 1'b0;
    wb_xfer(1'b1, 32'h3000_0020, 32'h1, rd, lat);
    check("axw_tmo_lat", lat, TMO + 1);
    check("axw_tmo_valids", {awvalid, wvalid}, 0);
    wb_xfer(1'b1, 32'h3000_0080, 32'h77, rd, lat);
    wb_xfer(1'b0, 32'h3000_0088, 32'h0, rd, lat);
    check("status_axi_err", rd, 32'h8000_0001);

    // Reset in the middle of an AXI-Lite read
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0004;
    repeat (3) begin @(posedge wb_clk_i); #1; end
    check("mid_rd_arvalid", arvalid, 1);
    wb_rst_i = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("rst_mid_valids", {awvalid, wvalid, arvalid, rready, ss_tvalid}, 0);
    check("rst_mid_ack", wbs_ack_o, 0);
    check("rst_mid_dat", wbs_dat_o, 0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("rst_mid_no_ack", wbs_ack_o, 0);
    check("rst_mid_sm_tready", sm_tready, 1);
    wb_xfer(1'b0, 32'h3000_0088, 32'h0, rd, lat);
    check("status_after_rst", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
